multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Control unit for the multicycle RV32I datapath, the successor to the single-cycle core.
- One shared memory port, IR/OldPC/ALUOut/Data holding registers and a single ALU are sequenced across several cycles per instruction.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal. Main decode is a Moore FSM; ALU decode is combinational from ALUOp, funct3 and funct7.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready is ignored and treated as always 1.
- ILLEGAL_HALT, 1: 1 = an unsupported opcode enters HALT; 0 = it is treated as a NOP and returns to FETCH.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction opcode, IR[6:0]
- funct3  input  3  IR[14:12]
- funct7  input  7  IR[31:25]
- Zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
- MemWrite  output  1  memory write enable
- IRWrite  output  1  IR and OldPC load enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J
- RegWrite  output  1  register file write enable
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction
- halted  output  1  high while in HALT
- state  output  4  current state, for debug

Behaviour:
- Reset and clocking
  - State register only. reset sampled high at a rising edge sets state = FETCH.
  - While reset is high, PCWrite, MemWrite, IRWrite, RegWrite and instr_done are forced to 0.
  - Reset mid-instruction abandons the instruction; no write occurs in the reset cycle.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10, HALT 15.
- Transitions
  - FETCH -> DECODE when mem_ready, else stay.
  - DECODE dispatches on op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL; any other op -> HALT (ILLEGAL_HALT = 1) or FETCH (ILLEGAL_HALT = 0).
  - MEMADR -> MEMREAD if op = lw, else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready, else stay.
  - MEMWRITE -> FETCH when mem_ready, else stay.
  - MEMWB -> FETCH.
  - EXECUTER and EXECUTEI -> ALUWB.
  - JAL -> ALUWB.
  - ALUWB -> FETCH.
  - BEQ -> FETCH.
  - HALT -> HALT until reset.
- Per-state outputs (any output not listed is 0; ALUOp is internal)
  - FETCH: AdrSrc 0, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10; IRWrite = PCWrite = mem_ready.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00. This precomputes the branch target.
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1; MemWrite held at 1 for every cycle spent in the state.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00; PCWrite = Zero.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCWrite 1.
- ImmSrc: combinational from op in every state. I-type 000 for lw and ALU-immediate, 001 sw, 010 beq, 011 jal, 000 otherwise.
- ALU decode
  - ALUOp 00 -> add; 01 -> sub.
  - ALUOp 10: funct3 000 -> sub if op[5] and funct7[5] are both 1, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
- instr_done pulses high in:
  - MEMWB, ALUWB and BEQ;
  - MEMWRITE in the cycle mem_ready = 1;
  - DECODE when an illegal op is taken with ILLEGAL_HALT = 0.
- halted = 1 only in HALT; all write enables are 0 in HALT.
- Cycle counts with mem_ready tied high: lw 5, sw 4, R/I 4, jal 4, beq 3.

Test Plan:
- reset held high for 2 cycles with mem_ready = 1 -> all write enables 0 throughout; after release state = 0, PCWrite = 1, IRWrite = 1.
- lw (op 0000011), mem_ready tied high -> states 0,1,2,3,4; RegWrite = 1 only in state 4 with ResultSrc 01; instr_done pulses in cycle 5.
- sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite = 1 for 4 cycles; state 5 holds; instr_done pulses only in the cycle mem_ready = 1.
- R-type sub (funct3 000, funct7 0100000) -> ALUControl 001 in EXECUTER. Same fields on the I-type op -> ALUControl 000 (addi). funct3 111 -> 010; 110 -> 011; 010 -> 101.
- beq with Zero = 1 -> PCWrite = 1 in BEQ; with Zero = 0 -> PCWrite = 0; both take 3 cycles. jal -> PCWrite = 1 in JAL, then RegWrite = 1 in ALUWB.
- op 1111111 with ILLEGAL_HALT = 1 -> state 15, halted = 1, no writes for 10 cycles, leaves only on reset. With ILLEGAL_HALT = 0 -> returns to FETCH, instr_done pulses in DECODE.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control unit: Moore main FSM plus a combinational ALU decoder.
// Each instruction takes 3-5 cycles. FETCH, MEMREAD and MEMWRITE stall on mem_ready.
module multicycle_control_fsm #(
  parameter logic USE_MEM_READY = 1'b1,
  parameter logic ILLEGAL_HALT  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       instr_done,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [6:0] op_lw   = 7'b0000011;
  localparam logic [6:0] op_sw   = 7'b0100011;
  localparam logic [6:0] op_rtyp = 7'b0110011;
  localparam logic [6:0] op_ityp = 7'b0010011;
  localparam logic [6:0] op_beq  = 7'b1100011;
  localparam logic [6:0] op_jal  = 7'b1101111;

  typedef enum logic [3:0] {
    s_fetch    = 4'd0,
    s_decode   = 4'd1,
    s_memadr   = 4'd2,
    s_memread  = 4'd3,
    s_memwb    = 4'd4,
    s_memwrite = 4'd5,
    s_executer = 4'd6,
    s_executei = 4'd7,
    s_aluwb    = 4'd8,
    s_beq      = 4'd9,
    s_jal      = 4'd10,
    s_halt     = 4'd15
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic       mem_rdy;
  logic       op_legal;
  logic [1:0] alu_op;
  logic       pc_write_raw;
  logic       mem_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       done_raw;
  logic       unused_funct7;

  assign mem_rdy       = USE_MEM_READY ? mem_ready : 1'b1;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    op_legal = 1'b0;
    case (op)
      op_lw, op_sw, op_rtyp, op_ityp, op_beq, op_jal: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) cur_state <= s_fetch;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      s_fetch:    if (mem_rdy) nxt_state = s_decode;
      s_decode: begin
        case (op)
          op_lw, op_sw: nxt_state = s_memadr;
          op_rtyp:      nxt_state = s_executer;
          op_ityp:      nxt_state = s_executei;
          op_beq:       nxt_state = s_beq;
          op_jal:       nxt_state = s_jal;
          default:      nxt_state = ILLEGAL_HALT ? s_halt : s_fetch;
        endcase
      end
      s_memadr:   nxt_state = (op == op_lw) ? s_memread : s_memwrite;
      s_memread:  if (mem_rdy) nxt_state = s_memwb;
      s_memwrite: if (mem_rdy) nxt_state = s_fetch;
      s_memwb:    nxt_state = s_fetch;
      s_executer: nxt_state = s_aluwb;
      s_executei: nxt_state = s_aluwb;
      s_jal:      nxt_state = s_aluwb;
      s_aluwb:    nxt_state = s_fetch;
      s_beq:      nxt_state = s_fetch;
      s_halt:     nxt_state = s_halt;
      // Unused encodings recover to a clean instruction boundary.
      default:    nxt_state = s_fetch;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    done_raw      = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    halted        = 1'b0;
    case (cur_state)
      s_fetch: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_rdy;
        pc_write_raw = mem_rdy;
      end
      s_decode: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b01;
        done_raw = !op_legal && !ILLEGAL_HALT;
      end
      s_memadr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      s_memread: AdrSrc = 1'b1;
      s_memwrite: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = mem_rdy;
      end
      s_memwb: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      s_executer: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      s_executei: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      s_aluwb: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      s_beq: begin
        ALUSrcA      = 2'b10;
        alu_op       = 2'b01;
        pc_write_raw = Zero;
        done_raw     = 1'b1;
      end
      s_jal: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      s_halt:  halted = 1'b1;
      default: ;
    endcase
  end

  // Reset abandons the instruction in flight, so no write may land in that cycle.
  assign PCWrite    = pc_write_raw  && !reset;
  assign MemWrite   = mem_write_raw && !reset;
  assign IRWrite    = ir_write_raw  && !reset;
  assign RegWrite   = reg_write_raw && !reset;
  assign instr_done = done_raw      && !reset;
  assign state      = cur_state;

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      op_sw:   ImmSrc = 3'b001;
      op_beq:  ImmSrc = 3'b010;
      op_jal:  ImmSrc = 3'b011;
      default: ImmSrc = 3'b000;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          // Only R-type uses funct7[5] to pick sub; addi shares the encoding.
          3'b000:  ALUControl = (op[5] && funct7[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench: stimulus queues the hand-computed control word for every cycle,
// a negedge monitor pops and compares it against the selected DUT.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset, reset1;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero, mem_ready;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  logic [3:0] state;

  logic       PCWrite1, AdrSrc1, MemWrite1, IRWrite1, RegWrite1, instr_done1, halted1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1;
  logic [2:0] ALUControl1, ImmSrc1;
  logic [3:0] state1;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.USE_MEM_READY(1'b1), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done),
    .halted(halted), .state(state)
  );

  multicycle_control_fsm #(.USE_MEM_READY(1'b1), .ILLEGAL_HALT(1'b0)) dut_nop (
    .clk(clk), .reset(reset1), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite1), .AdrSrc(AdrSrc1),
    .MemWrite(MemWrite1), .IRWrite(IRWrite1), .ResultSrc(ResultSrc1),
    .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUControl(ALUControl1),
    .ImmSrc(ImmSrc1), .RegWrite(RegWrite1), .instr_done(instr_done1),
    .halted(halted1), .state(state1)
  );

  // Word layout: state, {PCWrite,MemWrite,IRWrite,RegWrite}, AdrSrc, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUControl, ImmSrc, {instr_done,halted}.
  logic [22:0] act0, act1;
  assign act0 = {state, PCWrite, MemWrite, IRWrite, RegWrite, AdrSrc, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, instr_done, halted};
  assign act1 = {state1, PCWrite1, MemWrite1, IRWrite1, RegWrite1, AdrSrc1, ResultSrc1,
                 ALUSrcA1, ALUSrcB1, ALUControl1, ImmSrc1, instr_done1, halted1};

  typedef struct packed {
    logic        sel;
    logic [22:0] v;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic cur_sel = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_t x;
        logic [22:0] a;
        x = q.pop_front();
        a = x.sel ? act1 : act0;
        n_vec++;
        if (a !== x.v) begin
          n_bad++;
          $display("FAIL vec%0d dut%0d: got st=%0d word=%h, want st=%0d word=%h",
                   n_vec, x.sel, a[22:19], a, x.v[22:19], x.v);
        end
      end
    end
  end

  // we = {PCWrite, MemWrite, IRWrite, RegWrite}; fl = {instr_done, halted}.
  task automatic e(input logic [3:0] st, input logic [3:0] we, input logic adr,
                   input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                   input logic [2:0] alu, input logic [2:0] imm, input logic [1:0] fl);
    exp_t x;
    x.sel = cur_sel;
    x.v   = {st, we, adr, rs, sa, sb, alu, imm, fl};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    op     = o;
    funct3 = f3;
    funct7 = f7;
  endtask

  logic [2:0] f3_tab  [3];
  logic [2:0] alu_tab [3];

  initial begin
    f3_tab  = '{3'b111, 3'b110, 3'b010};
    alu_tab = '{3'b010, 3'b011, 3'b101};
    reset = 1'b1; reset1 = 1'b1;
    Zero = 1'b0; mem_ready = 1'b1;
    ins(7'b0000011, 3'b010, 7'b0000000);
    @(posedge clk); #1;

    // Reset held two cycles: FETCH outputs with every write enable masked.
    e(4'd0, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd0, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    reset = 1'b0;

    // lw, mem_ready high: 5 cycles.
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
    e(4'd2, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00);
    e(4'd3, 4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00);
    e(4'd4, 4'b0001, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);

    // sw with one FETCH stall and three MEMWRITE stalls.
    ins(7'b0100011, 3'b010, 7'b0000000);
    mem_ready = 1'b0;
    e(4'd0, 4'b0000, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 2'b00);
    mem_ready = 1'b1;
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b001, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b001, 2'b00);
    e(4'd2, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 2'b00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      e(4'd5, 4'b0100, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 2'b00);
    mem_ready = 1'b1;
    e(4'd5, 4'b0100, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b001, 2'b10);

    // R-type sub.
    ins(7'b0110011, 3'b000, 7'b0100000);
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
    e(4'd6, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 2'b00);
    e(4'd8, 4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);

    // Same fields on the I-type opcode decode as addi.
    ins(7'b0010011, 3'b000, 7'b0100000);
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
    e(4'd7, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 2'b00);
    e(4'd8, 4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);

    // R-type and / or / slt.
    for (int k = 0; k < 3; k++) begin
      ins(7'b0110011, f3_tab[k], 7'b0000000);
      e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
      e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
      e(4'd6, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b00, alu_tab[k], 3'b000, 2'b00);
      e(4'd8, 4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b10);
    end

    // beq taken, then not taken.
    ins(7'b1100011, 3'b000, 7'b0000000);
    Zero = 1'b1;
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 2'b00);
    e(4'd9, 4'b1000, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 2'b10);
    Zero = 1'b0;
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b010, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 2'b00);
    e(4'd9, 4'b0000, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b010, 2'b10);

    // jal.
    ins(7'b1101111, 3'b000, 7'b0000000);
    e(4'd0,  4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b011, 2'b00);
    e(4'd1,  4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 2'b00);
    e(4'd10, 4'b1000, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b011, 2'b00);
    e(4'd8,  4'b0001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b011, 2'b10);

    // Illegal op halts; inputs wiggle to show nothing writes.
    ins(7'b1111111, 3'b000, 7'b0000000);
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b00);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      Zero      = i[1];
      e(4'd15, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01);
    end
    mem_ready = 1'b1; Zero = 1'b0;
    reset = 1'b1;
    e(4'd15, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01);
    reset = 1'b0;
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);

    // Illegal op as NOP on the second instance.
    cur_sel = 1'b1;
    reset1  = 1'b0;
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);
    e(4'd1, 4'b0000, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b000, 2'b10);
    e(4'd0, 4'b1010, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
